conv_window_sequencer: RTL and testbench

- Sequences the 3x3 convolver over a raster-scan 8-bit pixel stream.
- Buffers two image lines and builds the 3x3 subframe window for every valid output position.
- Drives the convolver's nine subframe and nine kernel inputs, and tracks the convolver's fixed latency so each result leaves with a valid strobe.
- Sits between the pixel source (video/DMA) and the convolver; owns kernel register configuration.

---
 rtl/conv_pkg.sv | 21 ++
 rtl/conv_line_buffer.sv | 34 +++
 rtl/conv_window_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_conv_window_sequencer.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants and types for the 3x3 convolution window sequencer.
package conv_pkg;

   localparam int unsigned NB_DATA     = 8;
   localparam int unsigned KERNEL_SIZE = 9;
   localparam int unsigned NBF_COEFF   = 7;

   typedef enum logic [1:0] {StIdle, StFill, StRun, StDrain} state_e;

   // Window taps in raster order: index = row*3 + col.
   localparam int unsigned WIN_TL = 0;
   localparam int unsigned WIN_TC = 1;
   localparam int unsigned WIN_TR = 2;
   localparam int unsigned WIN_ML = 3;
   localparam int unsigned WIN_MC = 4;
   localparam int unsigned WIN_MR = 5;
   localparam int unsigned WIN_BL = 6;
   localparam int unsigned WIN_BC = 7;
   localparam int unsigned WIN_BR = 8;

endpackage

// File: rtl/conv_line_buffer.sv
// Two-line pixel store: one write port, two async read ports (older and newer line).
// The line being overwritten is always the older one; rotation swaps the roles.
module conv_line_buffer #(
   parameter int unsigned DEPTH = 640,
   parameter int unsigned WIDTH = 8,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_we,
   input  logic             i_rotate,
   input  logic [AW-1:0]    i_addr,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_top,
   output logic [WIDTH-1:0] o_mid
);

   logic [WIDTH-1:0] mem_q [2][DEPTH];
   logic             sel_q;

   always_ff @(posedge i_clk) begin
      if (i_we) mem_q[sel_q][i_addr] <= i_data;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)       sel_q <= 1'b0;
      else if (i_rotate) sel_q <= ~sel_q;
   end

   // Reads see the pre-write contents, so the current pixel never appears as its own top.
   assign o_top = mem_q[sel_q][i_addr];
   assign o_mid = mem_q[~sel_q][i_addr];

endmodule

// File: rtl/conv_window_sequencer.sv
// Builds 3x3 windows from a raster pixel stream and tracks the convolver latency.
// Define CONV_KERNEL_SHADOW_EN to stage kernel writes until the next start of frame.
module conv_window_sequencer #(
   parameter int unsigned IMG_WIDTH    = 640,
   parameter int unsigned IMG_HEIGHT   = 480,
   parameter int unsigned NB_DATA      = conv_pkg::NB_DATA,
   parameter int unsigned CONV_LATENCY = 2
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic                   i_valid,
   output logic                   o_ready,
   input  logic [NB_DATA-1:0]     i_pixel,
   input  logic                   i_sof,
   input  logic                   i_kernel_we,
   input  logic [3:0]             i_kernel_addr,
   input  logic [NB_DATA-1:0]     i_kernel_data,
   output logic [9*NB_DATA-1:0]   o_kernel,
   output logic [9*NB_DATA-1:0]   o_window,
   output logic                   o_win_valid,
   input  logic [NB_DATA-1:0]     i_conv,
   output logic [NB_DATA-1:0]     o_pix,
   output logic                   o_pix_valid,
   output logic                   o_eof,
   output logic                   o_busy
);
   import conv_pkg::*;

   localparam int unsigned CW = $clog2(IMG_WIDTH);
   localparam int unsigned RW = $clog2(IMG_HEIGHT);
   localparam int unsigned DW = $clog2(CONV_LATENCY + 2);
   localparam logic [CW-1:0] COL_LAST   = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_HEIGHT - 1);
   localparam logic [DW-1:0] DRAIN_LAST = DW'(CONV_LATENCY);

   state_e             state_q, state_d;
   logic [CW-1:0]      col_q, col_d, wr_addr;
   logic [RW-1:0]      row_q, row_d;
   logic [DW-1:0]      drain_q, drain_d;
   logic               ready_q, accept, sof_hit, wr_en, rotate, win_vld_d, win_eof_d;
   logic [NB_DATA-1:0] top_pix, mid_pix, pix_q;
   logic [NB_DATA-1:0] win_q [KERNEL_SIZE];
   logic [NB_DATA-1:0] kernel_q [KERNEL_SIZE];
   logic [CONV_LATENCY:0] vld_q, eofp_q;
   logic               pix_valid_q, eof_q;

   assign accept  = i_valid && ready_q;
   assign sof_hit = accept && i_sof;
   assign wr_addr = sof_hit ? '0 : col_q;

   conv_line_buffer #(
      .DEPTH (IMG_WIDTH),
      .WIDTH (NB_DATA)
   ) u_line_buffer (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_we     (wr_en),
      .i_rotate (rotate),
      .i_addr   (wr_addr),
      .i_data   (i_pixel),
      .o_top    (top_pix),
      .o_mid    (mid_pix)
   );

   always_comb begin
      state_d   = state_q;
      col_d     = col_q;
      row_d     = row_q;
      drain_d   = '0;
      wr_en     = 1'b0;
      rotate    = 1'b0;
      win_vld_d = 1'b0;
      win_eof_d = 1'b0;
      unique case (state_q)
         StIdle, StFill, StRun: begin
            // A start-of-frame pixel always restarts the frame as column 0.
            if (sof_hit) begin
               state_d = StFill;
               col_d   = CW'(1);
               row_d   = '0;
               wr_en   = 1'b1;
            end else if (accept && state_q != StIdle) begin
               wr_en     = 1'b1;
               win_vld_d = (state_q == StRun) && (col_q >= CW'(2));
               win_eof_d = win_vld_d && (row_q == ROW_LAST) && (col_q == COL_LAST);
               if (col_q == COL_LAST) begin
                  col_d  = '0;
                  rotate = 1'b1;
                  if (row_q == ROW_LAST) begin
                     row_d   = '0;
                     state_d = StDrain;
                  end else begin
                     row_d = row_q + 1'b1;
                     if (row_q == RW'(1)) state_d = StRun;
                  end
               end else begin
                  col_d = col_q + 1'b1;
               end
            end
         end
         StDrain: begin
            if (drain_q == DRAIN_LAST) state_d = StIdle;
            else                       drain_d = drain_q + 1'b1;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q     <= StIdle;
         col_q       <= '0;
         row_q       <= '0;
         drain_q     <= '0;
         ready_q     <= 1'b0;
         vld_q       <= '0;
         eofp_q      <= '0;
         pix_q       <= '0;
         pix_valid_q <= 1'b0;
         eof_q       <= 1'b0;
      end else begin
         state_q   <= state_d;
         col_q     <= col_d;
         row_q     <= row_d;
         drain_q   <= drain_d;
         ready_q   <= (state_d != StDrain);
         vld_q[0]  <= win_vld_d;
         eofp_q[0] <= win_eof_d;
         for (int unsigned i = 1; i <= CONV_LATENCY; i++) begin
            vld_q[i]  <= vld_q[i-1];
            eofp_q[i] <= eofp_q[i-1];
         end
         pix_valid_q <= vld_q[CONV_LATENCY];
         eof_q       <= eofp_q[CONV_LATENCY];
         if (vld_q[CONV_LATENCY]) pix_q <= i_conv;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         for (int unsigned k = 0; k < KERNEL_SIZE; k++) win_q[k] <= '0;
      end else if (wr_en) begin
         win_q[WIN_TL] <= win_q[WIN_TC];
         win_q[WIN_TC] <= win_q[WIN_TR];
         win_q[WIN_TR] <= top_pix;
         win_q[WIN_ML] <= win_q[WIN_MC];
         win_q[WIN_MC] <= win_q[WIN_MR];
         win_q[WIN_MR] <= mid_pix;
         win_q[WIN_BL] <= win_q[WIN_BC];
         win_q[WIN_BC] <= win_q[WIN_BR];
         win_q[WIN_BR] <= i_pixel;
      end
   end

`ifdef CONV_KERNEL_SHADOW_EN
   logic [NB_DATA-1:0] shadow_q [KERNEL_SIZE];

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         for (int unsigned k = 0; k < KERNEL_SIZE; k++) begin
            shadow_q[k] <= '0;
            kernel_q[k] <= '0;
         end
      end else begin
         if (i_kernel_we && i_kernel_addr < 4'(KERNEL_SIZE)) begin
            shadow_q[i_kernel_addr] <= i_kernel_data;
         end
         if (sof_hit) kernel_q <= shadow_q;
      end
   end
`else
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         for (int unsigned k = 0; k < KERNEL_SIZE; k++) kernel_q[k] <= '0;
      end else if (i_kernel_we && i_kernel_addr < 4'(KERNEL_SIZE)) begin
         kernel_q[i_kernel_addr] <= i_kernel_data;
      end
   end
`endif

   always_comb begin
      o_window = '0;
      o_kernel = '0;
      for (int unsigned k = 0; k < KERNEL_SIZE; k++) begin
         o_window[k*NB_DATA +: NB_DATA] = win_q[k];
         o_kernel[k*NB_DATA +: NB_DATA] = kernel_q[k];
      end
   end

   assign o_ready     = ready_q;
   assign o_win_valid = vld_q[0];
   assign o_pix       = pix_q;
   assign o_pix_valid = pix_valid_q;
   assign o_eof       = eof_q;
   assign o_busy      = (state_q != StIdle);

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Self-checking bench: 5x4 ramp frames, scoreboarded windows/results, kernel and reset cases.
module tb_conv_window_sequencer;

   localparam int W  = 5;
   localparam int H  = 4;
   localparam int L  = 2;
   localparam int NB = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          valid = 1'b0;
   logic          ready;
   logic [NB-1:0] pixel = '0;
   logic          sof = 1'b0;
   logic          kwe = 1'b0;
   logic [3:0]    kaddr = '0;
   logic [NB-1:0] kdata = '0;
   logic [71:0]   kernel, window;
   logic          win_valid;
   logic [NB-1:0] conv;
   logic [NB-1:0] pix;
   logic          pix_valid, eof, busy;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int pix_cnt = 0;
   int eof_cnt = 0;
   int win_cnt = 0;

   logic [71:0] win_exp [$];
   logic [8:0]  pix_exp [$];
   int          lat_q [$];
   logic [7:0]  kexp [9];
   logic [7:0]  ksh [9];
   logic [7:0]  cp0, cp1;

   conv_window_sequencer #(
      .IMG_WIDTH    (W),
      .IMG_HEIGHT   (H),
      .NB_DATA      (NB),
      .CONV_LATENCY (L)
   ) dut (
      .i_clk         (clk),
      .i_reset       (rst),
      .i_valid       (valid),
      .o_ready       (ready),
      .i_pixel       (pixel),
      .i_sof         (sof),
      .i_kernel_we   (kwe),
      .i_kernel_addr (kaddr),
      .i_kernel_data (kdata),
      .o_kernel      (kernel),
      .o_window      (window),
      .o_win_valid   (win_valid),
      .i_conv        (conv),
      .o_pix         (pix),
      .o_pix_valid   (pix_valid),
      .o_eof         (eof),
      .o_busy        (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Stand-in convolver: returns the window centre L cycles after presentation.
   always @(posedge clk) begin
      cp0 <= window[4*NB +: NB];
      cp1 <= cp0;
   end
   assign conv = cp1;

   always @(negedge clk) begin
      if (!rst) begin
         if (win_valid) begin
            win_cnt++;
            n_checks++;
            if (win_exp.size() == 0) begin
               n_errors++;
               $display("FAIL window_unexpected: got %h, none expected", window);
            end else begin
               logic [71:0] we_v;
               we_v = win_exp.pop_front();
               if (window !== we_v) begin
                  n_errors++;
                  $display("FAIL window: got %h expected %h", window, we_v);
               end
            end
            lat_q.push_back(cyc);
         end
         if (pix_valid) begin
            pix_cnt++;
            if (eof) eof_cnt++;
            n_checks++;
            if (pix_exp.size() == 0) begin
               n_errors++;
               $display("FAIL pix_unexpected: got pix=%h eof=%b", pix, eof);
            end else begin
               logic [8:0] pe;
               pe = pix_exp.pop_front();
               if ({eof, pix} !== pe) begin
                  n_errors++;
                  $display("FAIL pix: got eof=%b pix=%h expected eof=%b pix=%h",
                           eof, pix, pe[8], pe[7:0]);
               end
            end
            n_checks++;
            if (lat_q.size() == 0) begin
               n_errors++;
               $display("FAIL latency: pix valid with no window before it");
            end else begin
               int t;
               t = lat_q.pop_front();
               if (cyc - t != L + 1) begin
                  n_errors++;
                  $display("FAIL latency: got %0d cycles expected %0d", cyc - t, L + 1);
               end
            end
         end else if (eof) begin
            n_errors++;
            $display("FAIL eof_without_valid: got eof=1 expected 0");
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic logic [71:0] pack_k();
      logic [71:0] v;
      for (int k = 0; k < 9; k++) v[k*8 +: 8] = kexp[k];
      return v;
   endfunction

   task automatic drive_pixel(input int r, input int c, input logic s);
      int guard = 0;
      valid = 1'b1;
      sof   = s;
      pixel = 8'(10*r + c);
      while (!ready && guard < 20) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (guard >= 20) begin
         n_checks++;
         n_errors++;
         $display("FAIL ready_timeout: got ready=0 expected 1 at r=%0d c=%0d", r, c);
      end
      if (r >= 2 && c >= 2) begin
         logic [71:0] w;
         logic        e;
         for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
               w[(i*3 + j)*8 +: 8] = 8'(10*(r - 2 + i) + (c - 2 + j));
         e = (r == H - 1) && (c == W - 1);
         win_exp.push_back(w);
         pix_exp.push_back({e, 8'(10*(r - 1) + (c - 1))});
      end
      @(posedge clk);
      #1;
      valid = 1'b0;
      sof   = 1'b0;
`ifdef CONV_KERNEL_SHADOW_EN
      if (s) kexp = ksh;
`endif
   endtask

   task automatic send_frame(input bit gaps);
      for (int idx = 0; idx < W*H; idx++) begin
         drive_pixel(idx / W, idx % W, idx == 0);
         if (gaps) begin
            @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic wait_drain();
      int guard = 0;
      while ((busy || win_exp.size() != 0 || pix_exp.size() != 0) && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      repeat (2) @(negedge clk);
      n_checks++;
      if (guard >= 100) begin
         n_errors++;
         $display("FAIL drain_timeout: busy=%b win_left=%0d pix_left=%0d expected idle",
                  busy, win_exp.size(), pix_exp.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic write_kernel(input logic [3:0] a, input logic [7:0] d);
      kwe = 1'b1;
      kaddr = a;
      kdata = d;
      @(posedge clk);
      #1;
      kwe = 1'b0;
      if (a < 9) begin
`ifdef CONV_KERNEL_SHADOW_EN
         ksh[a] = d;
`else
         kexp[a] = d;
`endif
      end
   endtask

   task automatic test_reset();
      for (int k = 0; k < 9; k++) begin
         kexp[k] = '0;
         ksh[k]  = '0;
      end
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({ready, busy, win_valid, pix_valid, eof} !== 5'b0 || kernel !== '0 ||
          window !== '0 || pix !== '0) begin
         n_errors++;
         $display("FAIL reset_outputs: got rdy=%b busy=%b wv=%b pv=%b eof=%b expected all 0",
                  ready, busy, win_valid, pix_valid, eof);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_checks++;
      if (ready !== 1'b0) begin
         n_errors++;
         $display("FAIL ready_at_release: got %b expected 0", ready);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (ready !== 1'b1 || busy !== 1'b0) begin
         n_errors++;
         $display("FAIL idle_after_release: got rdy=%b busy=%b expected 1 0", ready, busy);
      end
   endtask

   task automatic test_kernel_config();
      write_kernel(4'd4, 8'h7F);
      n_checks++;
      if (kernel !== pack_k()) begin
         n_errors++;
         $display("FAIL kernel_cfg: got %h expected %h", kernel, pack_k());
      end
      write_kernel(4'd12, 8'h55);
      n_checks++;
      if (kernel !== pack_k()) begin
         n_errors++;
         $display("FAIL kernel_addr12: got %h expected %h", kernel, pack_k());
      end
   endtask

   task automatic test_idle_drop();
      int w0;
      w0 = win_cnt;
      for (int i = 0; i < 4; i++) begin
         valid = 1'b1;
         sof   = 1'b0;
         pixel = 8'hAA;
         @(posedge clk);
         #1;
         n_checks++;
         if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL idle_busy: got %b expected 0", busy);
         end
      end
      valid = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      n_checks++;
      if (win_cnt != w0) begin
         n_errors++;
         $display("FAIL idle_windows: got %0d windows expected 0", win_cnt - w0);
      end
   endtask

   task automatic test_frame(input bit gaps);
      int p0, e0;
      p0 = pix_cnt;
      e0 = eof_cnt;
      send_frame(gaps);
      wait_drain();
      n_checks++;
      if (pix_cnt - p0 != 6 || eof_cnt - e0 != 1) begin
         n_errors++;
         $display("FAIL frame_count gaps=%0d: got %0d pix %0d eof expected 6 1",
                  gaps, pix_cnt - p0, eof_cnt - e0);
      end
      n_checks++;
      if (kernel !== pack_k()) begin
         n_errors++;
         $display("FAIL frame_kernel: got %h expected %h", kernel, pack_k());
      end
   endtask

   task automatic test_sof_restart();
      int p0, e0;
      p0 = pix_cnt;
      e0 = eof_cnt;
      for (int idx = 0; idx <= 2*W; idx++) drive_pixel(idx / W, idx % W, idx == 0);
      n_checks++;
      if (busy !== 1'b1) begin
         n_errors++;
         $display("FAIL restart_busy: got %b expected 1", busy);
      end
      send_frame(1'b0);
      wait_drain();
      n_checks++;
      if (pix_cnt - p0 != 6 || eof_cnt - e0 != 1) begin
         n_errors++;
         $display("FAIL restart_count: got %0d pix %0d eof expected 6 1",
                  pix_cnt - p0, eof_cnt - e0);
      end
   endtask

   task automatic test_kernel_write();
      for (int idx = 0; idx < W*H; idx++) begin
         if (idx == 2*W + 2) begin
            kwe   = 1'b1;
            kaddr = 4'd0;
            kdata = 8'h40;
         end
         drive_pixel(idx / W, idx % W, idx == 0);
         if (idx == 2*W + 2) begin
            kwe = 1'b0;
`ifdef CONV_KERNEL_SHADOW_EN
            ksh[0] = 8'h40;
`else
            kexp[0] = 8'h40;
`endif
            n_checks++;
            if (kernel[7:0] !== kexp[0]) begin
               n_errors++;
               $display("FAIL kernel_write_run: got %h expected %h", kernel[7:0], kexp[0]);
            end
         end
      end
      wait_drain();
      test_frame(1'b0);
   endtask

   task automatic test_reset_mid_run();
      int p1;
      for (int idx = 0; idx <= 3*W + 2; idx++) drive_pixel(idx / W, idx % W, idx == 0);
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if ({ready, busy, win_valid, pix_valid, eof} !== 5'b0 || kernel !== '0 ||
          window !== '0 || pix !== '0) begin
         n_errors++;
         $display("FAIL reset_mid_run: got rdy=%b busy=%b wv=%b pv=%b eof=%b expected all 0",
                  ready, busy, win_valid, pix_valid, eof);
      end
      win_exp.delete();
      pix_exp.delete();
      lat_q.delete();
      for (int k = 0; k < 9; k++) begin
         kexp[k] = '0;
         ksh[k]  = '0;
      end
      p1 = pix_cnt;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_checks++;
      if (ready !== 1'b0) begin
         n_errors++;
         $display("FAIL mid_reset_ready: got %b expected 0", ready);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (ready !== 1'b1 || busy !== 1'b0) begin
         n_errors++;
         $display("FAIL mid_reset_idle: got rdy=%b busy=%b expected 1 0", ready, busy);
      end
      repeat (10) @(posedge clk);
      #1;
      n_checks++;
      if (pix_cnt != p1) begin
         n_errors++;
         $display("FAIL mid_reset_spurious: got %0d pix valids expected 0", pix_cnt - p1);
      end
   endtask

   initial begin
      test_reset();
      test_kernel_config();
      test_idle_drop();
      test_frame(1'b0);
      test_frame(1'b1);
      test_sof_restart();
      test_kernel_write();
      test_reset_mid_run();
      n_checks++;
      if (win_exp.size() != 0 || pix_exp.size() != 0) begin
         n_errors++;
         $display("FAIL leftover: got %0d windows %0d results pending expected 0 0",
                  win_exp.size(), pix_exp.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
